// File: rtl/sbc_pkg.sv
// Shared limb width and FSM state encoding for the multi-limb subtract-with-borrow block.
package sbc_pkg;
    localparam int LIMB_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/sbc_limb.sv
// Combinational single-limb subtract-with-borrow: {O} = I0 - I1 - BIN, BOUT = borrow out.
module sbc_limb
    import sbc_pkg::*;
(
    input  logic [LIMB_W-1:0] I0,
    input  logic [LIMB_W-1:0] I1,
    input  logic              BIN,
    output logic [LIMB_W-1:0] O,
    output logic              BOUT
);
    logic [LIMB_W:0] diff;

    assign diff = {1'b0, I0} - {1'b0, I1} - {{LIMB_W{1'b0}}, BIN};
    assign O    = diff[LIMB_W-1:0];
    assign BOUT = diff[LIMB_W];
endmodule

// File: rtl/multi_limb_sbc.sv
// Streaming multi-limb subtractor, one limb per cycle, LS limb first, one-cycle latency.
// Signed overflow output is built only when MULTI_LIMB_SBC_OVF_EN is defined.
module multi_limb_sbc
    import sbc_pkg::*;
#(
    parameter int MAX_LIMBS = 8
) (
    input  logic              CLK,
    input  logic              ASYNCRESET,
    input  logic              I_valid,
    output logic              I_ready,
    input  logic [LIMB_W-1:0] I0,
    input  logic [LIMB_W-1:0] I1,
    input  logic              BIN,
    input  logic              I_last,
    output logic              O_valid,
    input  logic              O_ready,
    output logic [LIMB_W-1:0] O,
    output logic              O_last,
    output logic              BOUT,
    output logic              OVF,
    output logic              ERR
);
    localparam int CNT_W = $clog2(MAX_LIMBS);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              borrow;
    logic              accept;
    logic              compute;
    logic              overlong;
    logic              final_limb;
    logic              cin;
    logic [LIMB_W-1:0] limb_o;
    logic              limb_bout;

    // Ready is gated by reset so nothing can be taken while the block is held.
    assign I_ready    = !ASYNCRESET && ((state == DRAIN) || !O_valid || O_ready);
    assign accept     = I_valid && I_ready;
    assign compute    = accept && (state != DRAIN);
    assign overlong   = (cnt == CNT_W'(MAX_LIMBS - 1)) && !I_last;
    assign final_limb = I_last || overlong;
    assign cin        = (state == IDLE) ? BIN : borrow;

    sbc_limb u_limb (
        .I0   (I0),
        .I1   (I1),
        .BIN  (cin),
        .O    (limb_o),
        .BOUT (limb_bout)
    );

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            borrow  <= 1'b0;
            O_valid <= 1'b0;
            O       <= '0;
            O_last  <= 1'b0;
            BOUT    <= 1'b0;
            ERR     <= 1'b0;
        end else if (compute) begin
            O_valid <= 1'b1;
            O       <= limb_o;
            O_last  <= final_limb;
            BOUT    <= final_limb && limb_bout;
            ERR     <= overlong;
            borrow  <= limb_bout;
            cnt     <= final_limb ? '0 : cnt + 1'b1;
            if (overlong)    state <= DRAIN;
            else if (I_last) state <= IDLE;
            else             state <= BUSY;
        end else begin
            if (O_valid && O_ready) O_valid <= 1'b0;
            // Only reachable from DRAIN: overlong tail is swallowed until its last limb.
            if (accept && I_last) state <= IDLE;
        end
    end

`ifdef MULTI_LIMB_SBC_OVF_EN
    logic ovf_q;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET)   ovf_q <= 1'b0;
        else if (compute) ovf_q <= final_limb && (I0[LIMB_W-1] != I1[LIMB_W-1])
                                              && (limb_o[LIMB_W-1] != I0[LIMB_W-1]);
    end

    assign OVF = ovf_q;
`else
    assign OVF = 1'b0;
`endif
endmodule
